// File: rtl/eurorack_pmod_pkg.sv
// Shared constants and sequencer state type for the eurorack-pmod LED path.
// The I2C driver's LED mapping uses the same channel count and LED width.
package eurorack_pmod_pkg;
  localparam int N_CH  = 8;
  localparam int LED_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    COMMIT
  } seq_state_t;
endpackage

// File: rtl/led_level_meter_if.sv
// Sample/jack input side and LED/status output side of the level meter.
interface led_level_meter_if #(
  parameter int W = 16
);
  import eurorack_pmod_pkg::*;

  logic                 sample_strobe;
  logic [W-1:0]         sample0, sample1, sample2, sample3;
  logic [W-1:0]         sample4, sample5, sample6, sample7;
  logic [N_CH-1:0]      jack;
  logic [LED_W-1:0]     led0, led1, led2, led3, led4, led5, led6, led7;
  logic                 busy;
  logic                 overrun;

  modport master (
    output sample_strobe, sample0, sample1, sample2, sample3,
           sample4, sample5, sample6, sample7, jack,
    input  led0, led1, led2, led3, led4, led5, led6, led7, busy, overrun
  );

  modport slave (
    input  sample_strobe, sample0, sample1, sample2, sample3,
           sample4, sample5, sample6, sample7, jack,
    output led0, led1, led2, led3, led4, led5, led6, led7, busy, overrun
  );
endinterface

// File: rtl/meter_env_step.sv
// One envelope update for a single channel: instant attack, exponential decay,
// signed 8-bit LED byte derived from the top 7 bits of the new envelope.
module meter_env_step
  import eurorack_pmod_pkg::*;
#(
  parameter int W              = 16,
  parameter int DECAY_SHIFT    = 12,
  parameter int MASK_UNPLUGGED = 1
) (
  input  logic [W-1:0]     sample,
  input  logic [W-2:0]     env,
  input  logic             sign,
  input  logic             plugged,
  output logic [W-2:0]     env_next,
  output logic             sign_next,
  output logic [LED_W-1:0] led
);
  logic [W-2:0]     mag;
  logic [W-2:0]     decay;
  logic [6:0]       lvl;
  logic [LED_W-1:0] led_mag;

  always_comb begin
    mag       = sample[W-2:0];
    decay     = env >> DECAY_SHIFT;
    env_next  = env;
    sign_next = sign;

    // Most negative code has no positive twin, so it saturates to full scale.
    if (sample == {1'b1, {(W-1){1'b0}}}) begin
      mag = '1;
    end else if (sample[W-1]) begin
      mag = ~sample[W-2:0] + (W-1)'(1);
    end

    if (decay == '0 && env != '0) begin
      decay = (W-1)'(1);
    end

    if (MASK_UNPLUGGED != 0 && !plugged) begin
      env_next  = '0;
      sign_next = 1'b0;
    end else if (mag >= env) begin
      env_next  = mag;
      sign_next = sample[W-1];
    end else begin
      env_next  = env - decay;
    end

    lvl     = env_next[W-2:W-8];
    led_mag = {1'b0, lvl};
    led     = (sign_next && lvl != '0) ? (~led_mag + LED_W'(1)) : led_mag;
  end
endmodule

// File: rtl/led_level_meter.sv
// Peak-envelope LED meter: latches a sample frame, walks the 8 channels through
// one shared envelope step, then publishes all LEDs together in COMMIT.
module led_level_meter
  import eurorack_pmod_pkg::*;
#(
  parameter int W              = 16,
  parameter int DECAY_SHIFT    = 12,
  parameter int MASK_UNPLUGGED = 1
) (
  input logic               clk,
  input logic               rst,
  led_level_meter_if.slave  bus
);
  localparam int CH_W = $clog2(N_CH);

  seq_state_t       state_reg;
  logic [CH_W-1:0]  ch_reg;
  logic             busy_reg;
  logic             overrun_reg;
  logic [N_CH-1:0]  jack_reg;
  logic [W-1:0]     sample_reg   [N_CH];
  logic [W-2:0]     env_reg      [N_CH];
  logic             sign_reg     [N_CH];
  logic [LED_W-1:0] led_next_reg [N_CH];
  logic [LED_W-1:0] led_reg      [N_CH];

  logic [W-1:0]     sample_in [N_CH];
  logic [W-2:0]     step_env;
  logic             step_sign;
  logic [LED_W-1:0] step_led;

  assign sample_in[0] = bus.sample0;
  assign sample_in[1] = bus.sample1;
  assign sample_in[2] = bus.sample2;
  assign sample_in[3] = bus.sample3;
  assign sample_in[4] = bus.sample4;
  assign sample_in[5] = bus.sample5;
  assign sample_in[6] = bus.sample6;
  assign sample_in[7] = bus.sample7;

  meter_env_step #(
    .W              (W),
    .DECAY_SHIFT    (DECAY_SHIFT),
    .MASK_UNPLUGGED (MASK_UNPLUGGED)
  ) u_step (
    .sample    (sample_reg[ch_reg]),
    .env       (env_reg[ch_reg]),
    .sign      (sign_reg[ch_reg]),
    .plugged   (jack_reg[ch_reg]),
    .env_next  (step_env),
    .sign_next (step_sign),
    .led       (step_led)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ch_reg      <= '0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
      jack_reg    <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sample_reg[i]   <= '0;
        env_reg[i]      <= '0;
        sign_reg[i]     <= 1'b0;
        led_next_reg[i] <= '0;
        led_reg[i]      <= '0;
      end
    end else begin
      // A strobe outside IDLE (COMMIT included) is lost; the shadows stay put.
      if (bus.sample_strobe && state_reg != IDLE) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (bus.sample_strobe) begin
            for (int i = 0; i < N_CH; i++) begin
              sample_reg[i] <= sample_in[i];
            end
            jack_reg  <= bus.jack;
            ch_reg    <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          env_reg[ch_reg]      <= step_env;
          sign_reg[ch_reg]     <= step_sign;
          led_next_reg[ch_reg] <= step_led;
          ch_reg               <= ch_reg + CH_W'(1);
          if (ch_reg == CH_W'(N_CH - 1)) begin
            state_reg <= COMMIT;
          end
        end
        COMMIT: begin
          for (int i = 0; i < N_CH; i++) begin
            led_reg[i] <= led_next_reg[i];
          end
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.led0    = led_reg[0];
  assign bus.led1    = led_reg[1];
  assign bus.led2    = led_reg[2];
  assign bus.led3    = led_reg[3];
  assign bus.led4    = led_reg[4];
  assign bus.led5    = led_reg[5];
  assign bus.led6    = led_reg[6];
  assign bus.led7    = led_reg[7];
  assign bus.busy    = busy_reg;
  assign bus.overrun = overrun_reg;
endmodule

// File: tb/tb_led_level_meter.sv
// Scoreboard bench for led_level_meter: a behavioural envelope model predicts
// each committed LED frame, which is compared when the sequencer drops busy.
module tb_led_level_meter;
  import eurorack_pmod_pkg::*;

  localparam int W      = 16;
  localparam int DS     = 2;
  localparam int MAXMAG = (1 << (W - 1)) - 1;

  typedef logic [W-1:0] smp_t [N_CH];

  logic clk = 1'b0;
  logic rst;

  led_level_meter_if #(.W(W)) mbus ();

  led_level_meter #(
    .W              (W),
    .DECAY_SHIFT    (DS),
    .MASK_UNPLUGGED (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (mbus)
  );

  always #5 clk = ~clk;

  int          n_cmp   = 0;
  int          n_err   = 0;
  int          n_frame = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_led;
  int          env_m  [N_CH];
  bit          sign_m [N_CH];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] get_leds();
    return {mbus.led7, mbus.led6, mbus.led5, mbus.led4,
            mbus.led3, mbus.led2, mbus.led1, mbus.led0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      env_m[i]  = 0;
      sign_m[i] = 1'b0;
    end
    last_led = '0;
  endtask

  function automatic logic [63:0] model_frame(input smp_t s, input logic [7:0] jk);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < N_CH; i++) begin
      int v, mag, d, lvl;
      v   = int'($signed(s[i]));
      mag = (v < 0) ? -v : v;
      if (mag > MAXMAG) mag = MAXMAG;
      if (!jk[i]) begin
        env_m[i]  = 0;
        sign_m[i] = 1'b0;
      end else if (mag >= env_m[i]) begin
        env_m[i]  = mag;
        sign_m[i] = (v < 0);
      end else begin
        d = env_m[i] >> DS;
        if (d == 0) d = 1;
        env_m[i] = (env_m[i] > d) ? env_m[i] - d : 0;
      end
      lvl = env_m[i] >> (W - 8);
      f[8*i +: 8] = sign_m[i] ? 8'(-lvl) : 8'(lvl);
    end
    return f;
  endfunction

  task automatic set_bus(input smp_t s, input logic [7:0] jk);
    mbus.sample0 = s[0];
    mbus.sample1 = s[1];
    mbus.sample2 = s[2];
    mbus.sample3 = s[3];
    mbus.sample4 = s[4];
    mbus.sample5 = s[5];
    mbus.sample6 = s[6];
    mbus.sample7 = s[7];
    mbus.jack    = jk;
  endtask

  task automatic drive_strobe(input smp_t s, input logic [7:0] jk);
    set_bus(s, jk);
    mbus.sample_strobe = 1'b1;
    exp_q.push_back(model_frame(s, jk));
    @(posedge clk);
    #1;
    mbus.sample_strobe = 1'b0;
  endtask

  // inject_at > 0 fires a stray strobe in cycle T+inject_at of the frame.
  task automatic run_frame(input smp_t s, input logic [7:0] jk, input int inject_at);
    smp_t        junk;
    logic [63:0] exp;
    logic [63:0] obs;
    int          cyc;
    junk = '{default: 16'h7FFF};
    drive_strobe(s, jk);
    check_val("busy_set", 64'(mbus.busy), 64'd1);
    cyc = 1;
    while (mbus.busy === 1'b1 && cyc < 40) begin
      if (cyc == 9) check_val("hold", get_leds(), last_led);
      if (cyc == inject_at) begin
        set_bus(junk, 8'hFF);
        mbus.sample_strobe = 1'b1;
      end
      @(posedge clk);
      #1;
      mbus.sample_strobe = 1'b0;
      cyc++;
    end
    check_val("latency", 64'(cyc), 64'd10);
    check_val("sb_depth", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      obs = get_leds();
      for (int i = 0; i < N_CH; i++) begin
        check_val($sformatf("led%0d", i), 64'(obs[8*i +: 8]), 64'(exp[8*i +: 8]));
      end
      $display("frame %0d: jack=%h leds=%h exp=%h overrun=%b", n_frame, jk, obs, exp, mbus.overrun);
      last_led = exp;
    end
    n_frame++;
  endtask

  initial begin
    smp_t        s;
    logic [63:0] l;

    rst = 1'b1;
    mbus.sample_strobe = 1'b0;
    s = '{default: '0};
    set_bus(s, 8'h00);
    model_reset();

    // Reset: two cycles, then idle with no strobe
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_leds", get_leds(), 64'd0);
    check_val("rst_busy", 64'(mbus.busy), 64'd0);
    check_val("rst_overrun", 64'(mbus.overrun), 64'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_leds", get_leds(), 64'd0);
    check_val("idle_busy", 64'(mbus.busy), 64'd0);

    // Attack
    s = '{default: '0};
    s[3] = 16'h4000;
    run_frame(s, 8'hFF, 0);
    l = get_leds();
    check_val("attack", l, 64'h0000_0000_4000_0000);

    // Negative saturation, then decay with no sign change
    s = '{default: '0};
    s[5] = 16'h8000;
    run_frame(s, 8'hFF, 0);
    l = get_leds();
    check_val("sat_led5", 64'(l[47:40]), 64'h81);
    s = '{default: '0};
    run_frame(s, 8'hFF, 0);
    l = get_leds();
    check_val("decay1_led5", 64'(l[47:40]), 64'hA0);
    run_frame(s, 8'hFF, 0);
    l = get_leds();
    check_val("decay2_led5", 64'(l[47:40]), 64'hB8);
    for (int k = 0; k < 4; k++) run_frame(s, 8'hFF, 0);

    // Unplugged mask
    s = '{default: '0};
    s[0] = 16'h7FFF;
    s[1] = 16'h7FFF;
    run_frame(s, 8'hFE, 0);
    l = get_leds();
    check_val("unplug_led0", 64'(l[7:0]), 64'h00);
    check_val("unplug_led1", 64'(l[15:8]), 64'h7F);
    run_frame(s, 8'hFF, 0);
    l = get_leds();
    check_val("replug_led0", 64'(l[7:0]), 64'h7F);

    // Overrun: stray strobe mid-RUN, then another in the COMMIT cycle
    check_val("ovr_clear", 64'(mbus.overrun), 64'd0);
    s = '{default: '0};
    s[6] = 16'hC000;
    run_frame(s, 8'hFF, 4);
    l = get_leds();
    check_val("ovr_set", 64'(mbus.overrun), 64'd1);
    check_val("ovr_led6", 64'(l[55:48]), 64'hC0);
    s = '{default: '0};
    run_frame(s, 8'hFF, 9);
    check_val("ovr_sticky", 64'(mbus.overrun), 64'd1);
    check_val("ovr_idle", 64'(mbus.busy), 64'd0);

    // Reset mid-RUN
    s = '{default: '0};
    s[2] = 16'h2000;
    drive_strobe(s, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    check_val("mid_busy", 64'(mbus.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("abort_busy", 64'(mbus.busy), 64'd0);
    check_val("abort_leds", get_leds(), 64'd0);
    check_val("abort_overrun", 64'(mbus.overrun), 64'd0);
    exp_q.delete();
    model_reset();
    run_frame(s, 8'hFF, 0);
    l = get_leds();
    check_val("post_rst", l, 64'h0000_0000_0020_0000);

    // Random frames
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        s[i] = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      end
      run_frame(s, 8'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
